// File: rtl/lif_pkg.sv
// Shared types, default widths and the saturating adder for the LIF neuron.
package lif_pkg;

  localparam int LIF_N_SYN_DEF     = 4;
  localparam int LIF_W_DEF         = 8;
  localparam int LIF_REFRAC_W_DEF  = 4;
  localparam int LIF_ADAPT_INC_DEF = 4;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_t;

  // Adds two unsigned values and clamps to 2^w-1; callers keep w <= 31.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] max_v;
    s     = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (s > max_v) ? max_v[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_syn_sum.sv
// Combinational sum of the weights whose synapse input is active.
module lif_syn_sum
  import lif_pkg::*;
#(
  parameter int N_SYN = LIF_N_SYN_DEF,
  parameter int W     = LIF_W_DEF
) (
  input  logic [N_SYN-1:0]               syn,
  input  logic [N_SYN*W-1:0]             weight,
  output logic [W+$clog2(N_SYN)-1:0]     sum
);

  localparam int OUT_W = W + $clog2(N_SYN);

  // NOTE: combinational blocks use blocking '=' so the running sum accumulates in order;
  // the default assignment up front also keeps every path assigned, so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (syn[i]) sum = sum + OUT_W'(weight[i*W +: W]);
    end
  end

endmodule

// File: rtl/lif_neuron_multi.sv
// Multi-synapse leaky integrate-and-fire neuron with saturating integration and refractory period.
// Optional adaptive threshold enabled by defining LIF_ADAPT_THRESH_EN.
module lif_neuron_multi
  import lif_pkg::*;
#(
  parameter int N_SYN     = LIF_N_SYN_DEF,
  parameter int W         = LIF_W_DEF,
  parameter int REFRAC_W  = LIF_REFRAC_W_DEF,
  parameter int ADAPT_INC = LIF_ADAPT_INC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_SYN-1:0]       syn,
  input  logic [N_SYN*W-1:0]     weight,
  input  logic [$clog2(W)-1:0]   tau_shift,
  input  logic [W-1:0]           threshold,
  input  logic [W-1:0]           v_reset,
  input  logic [REFRAC_W-1:0]    refrac_cycles,
  output logic                   spike,
  output logic [W-1:0]           V,
  output logic                   refractory
);

  localparam int SYN_W = W + $clog2(N_SYN);
  localparam int SUM_W = SYN_W + 1;

  lif_state_t          state_q, state_d;
  logic [W-1:0]        v_q, v_d;
  logic                spike_q, spike_d;
  logic                refr_q, refr_d;
  logic [REFRAC_W-1:0] cnt_q, cnt_d;

  logic [SYN_W-1:0]    syn_sum;
  logic [W-1:0]        leak;
  logic [SUM_W-1:0]    sum_full;
  logic [W-1:0]        sum_sat;
  logic [W-1:0]        threshold_eff;
  logic                fire;

  lif_syn_sum #(.N_SYN(N_SYN), .W(W)) u_syn_sum (
    .syn    (syn),
    .weight (weight),
    .sum    (syn_sum)
  );

  always_comb begin
    leak     = (tau_shift == '0) ? v_q : v_q - (v_q >> tau_shift);
    sum_full = SUM_W'(leak) + SUM_W'(syn_sum);
    sum_sat  = (sum_full > SUM_W'({W{1'b1}})) ? {W{1'b1}} : sum_full[W-1:0];
    fire     = en && (state_q == INTEG) && (sum_sat >= threshold_eff);
  end

`ifdef LIF_ADAPT_THRESH_EN
  logic [W-1:0] theta_q, theta_d;

  always_comb begin
    threshold_eff = W'(sat_add(32'(threshold), 32'(theta_q), W));
    theta_d       = theta_q;
    if (fire) begin
      theta_d = W'(sat_add(32'(theta_q), 32'(ADAPT_INC), W));
    end else if (en && state_q == INTEG && theta_q != '0) begin
      theta_d = theta_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) theta_q <= '0;
    else        theta_q <= theta_d;
  end
`else
  assign threshold_eff = threshold;
`endif

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (en) begin
      case (state_q)
        INTEG: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = v_reset;
            cnt_d   = refrac_cycles;
            if (refrac_cycles != '0) state_d = REFRAC;
          end else begin
            v_d = sum_sat;
          end
        end
        REFRAC: begin
          // Synapses and leak are ignored; V keeps the post-spike value.
          cnt_d = cnt_q - REFRAC_W'(1);
          if (cnt_q == REFRAC_W'(1)) state_d = INTEG;
        end
        default: state_d = INTEG;
      endcase
    end
    refr_d = (state_d == REFRAC);
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INTEG;
      v_q     <= '0;
      spike_q <= 1'b0;
      refr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      refr_q  <= refr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike      = spike_q;
  assign V          = v_q;
  assign refractory = refr_q;

endmodule

// File: tb/tb_lif_neuron_multi.sv
// Scoreboard bench for lif_neuron_multi (W=8, N_SYN=4) with hand-computed expected vectors.
module tb_lif_neuron_multi;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  syn;
  logic [31:0] weight;
  logic [2:0]  tau_shift;
  logic [7:0]  threshold;
  logic [7:0]  v_reset;
  logic [3:0]  refrac_cycles;
  logic        spike;
  logic [7:0]  V;
  logic        refractory;

  lif_neuron_multi #(.N_SYN(4), .W(8), .REFRAC_W(4), .ADAPT_INC(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .syn           (syn),
    .weight        (weight),
    .tau_shift     (tau_shift),
    .threshold     (threshold),
    .v_reset       (v_reset),
    .refrac_cycles (refrac_cycles),
    .spike         (spike),
    .V             (V),
    .refractory    (refractory)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [9:0]  exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   vectors;
  int   miscompares;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got spike=%0b V=%0d refr=%0b, expected spike=%0b V=%0d refr=%0b",
               name, act[9], act[8:1], act[0], exp[9], exp[8:1], exp[0]);
    end
  endtask

  // Monitor: compares the outputs of each edge against the expectation queued for it.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name, {spike, V, refractory}, mon_e.exp);
    end
  end

  task automatic step(input string name, input logic e, input logic [3:0] s,
                      input logic x_spk, input logic [7:0] x_v, input logic x_ref);
    exp_t it;
    @(negedge clk);
    #1;
    en  = e;
    syn = s;
    it.cyc  = cyc + 1;
    it.name = name;
    it.exp  = {x_spk, x_v, x_ref};
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    #2;
  endtask

  logic [7:0] t3_v [9] = '{8'd100, 8'd50, 8'd25, 8'd13, 8'd7, 8'd4, 8'd2, 8'd1, 8'd1};
`ifdef LIF_ADAPT_THRESH_EN
  logic [7:0] t6_v [8] = '{8'd10, 8'd0, 8'd10, 8'd20, 8'd0, 8'd10, 8'd20, 8'd0};
  logic       t6_s [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en = 1'b0;
    syn = '0;
    weight = '0;
    tau_shift = '0;
    threshold = '0;
    v_reset = '0;
    refrac_cycles = '0;
    #12;
    check("reset_state", {spike, V, refractory}, 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pure integration, fire at 50, no refractory period.
    weight = {24'd0, 8'd10};
    threshold = 8'd50;
    for (int k = 1; k <= 10; k++) begin
      step("integrate_fire", 1'b1, 4'b0001, (k % 5 == 0),
           (k % 5 == 0) ? 8'd0 : 8'((k % 5) * 10), 1'b0);
    end

    // Leak with shift 1, flooring to a stall at 1.
    tau_shift = 3'd1;
    threshold = 8'd200;
    weight = {24'd0, 8'd100};
    for (int k = 0; k < 9; k++) begin
      step("leak_decay", 1'b1, (k == 0) ? 4'b0001 : 4'b0000, 1'b0, t3_v[k], 1'b0);
    end

    // Saturating sum, then threshold 0 fires every enabled cycle.
    tau_shift = 3'd0;
    threshold = 8'd255;
    v_reset = 8'd7;
    weight = {8'd255, 8'd255, 8'd255, 8'd255};
    step("saturate_fire", 1'b1, 4'b1111, 1'b1, 8'd7, 1'b0);
    threshold = 8'd0;
    step("thresh0_a", 1'b1, 4'b0000, 1'b1, 8'd7, 1'b0);
    step("thresh0_b", 1'b1, 4'b0000, 1'b1, 8'd7, 1'b0);
    step("en_low_hold", 1'b0, 4'b0000, 1'b0, 8'd7, 1'b0);
    step("thresh0_c", 1'b1, 4'b0000, 1'b1, 8'd7, 1'b0);
    threshold = 8'd255;
    step("below_thresh", 1'b1, 4'b0000, 1'b0, 8'd7, 1'b0);

    // Refractory period of 3 en-cycles, stretched by one idle cycle.
    threshold = 8'd50;
    v_reset = 8'd5;
    refrac_cycles = 4'd3;
    weight = {8'd255, 8'd255, 8'd255, 8'd60};
    step("refrac_enter", 1'b1, 4'b0001, 1'b1, 8'd5, 1'b1);
    step("refrac_1", 1'b1, 4'b0001, 1'b0, 8'd5, 1'b1);
    step("refrac_2", 1'b1, 4'b0001, 1'b0, 8'd5, 1'b1);
    step("refrac_idle", 1'b0, 4'b0001, 1'b0, 8'd5, 1'b1);
    step("refrac_3", 1'b1, 4'b0001, 1'b0, 8'd5, 1'b0);
    step("refrac_resume", 1'b1, 4'b0001, 1'b1, 8'd5, 1'b1);
    drain();

    // Asynchronous reset while refractory, checked with no clock edge.
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_refrac", {spike, V, refractory}, 10'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LIF_ADAPT_THRESH_EN
    tau_shift = 3'd0;
    threshold = 8'd20;
    v_reset = 8'd0;
    refrac_cycles = 4'd0;
    weight = {24'd0, 8'd10};
    for (int k = 0; k < 8; k++) begin
      step("adapt_thresh", 1'b1, 4'b0001, t6_s[k], t6_v[k], 1'b0);
    end
`endif

    begin
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      #2;
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lif_neuron_multi.md
Name: lif_neuron_multi

Overview:
- Parametrised leaky integrate-and-fire neuron, successor to the single-synapse neuron.
- Adds N weighted synapse inputs, a configurable data width and saturating integration.
- Adds a registered one-cycle spike pulse, reset-to-potential after firing and a programmable refractory period.
- Instantiated per neuron inside the network layer; configuration is held quasi-static by the layer controller.

Parameters:
N_SYN, 4, number of binary synapse inputs
W, 8, membrane potential / weight / threshold width in bits
REFRAC_W, 4, width of refractory period counter
ADAPT_INC, 4, threshold increment per spike (used only with LIF_ADAPT_THRESH_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  integration enable (timestep strobe)
syn  in  N_SYN  synapse spike inputs, bit i selects weight i
weight  in  N_SYN*W  packed unsigned weights, weight i at [i*W +: W]
tau_shift  in  $clog2(W)  leak shift; 0 = no leak
threshold  in  W  firing threshold, unsigned
v_reset  in  W  potential loaded after a spike
refrac_cycles  in  REFRAC_W  refractory length in en-cycles; 0 = none
spike  out  1  registered one-cycle spike pulse
V  out  W  membrane potential register
refractory  out  1  high while in REFRAC state

Behaviour:
- Reset (rst_n low, asynchronous): V=0, spike=0, state=INTEG, refractory counter=0, refractory=0. Takes effect immediately, including mid-refractory.
- en=0: all state holds; spike forced 0 on the next edge.
- State INTEG, en=1:
  - leak = (tau_shift==0) ? V : V - (V >> tau_shift).
  - sum = leak + sum of weight_i over syn_i==1, computed in W+$clog2(N_SYN)+1 bits, saturated to 2^W-1.
  - If sum >= threshold_eff: spike<=1, V<=v_reset, counter<=refrac_cycles, state<=REFRAC if refrac_cycles!=0, else stay INTEG.
  - Otherwise: V<=sum, spike<=0.
- State REFRAC, en=1:
  - syn ignored, no leak, V holds v_reset, spike<=0, counter decrements.
  - When counter==1, state<=INTEG.
  - Result: exactly refrac_cycles en-cycles are ignored.
- Latency: syn sampled at edge n produces spike high and V=v_reset in cycle n+1; spike lasts exactly one cycle.
- threshold=0: fires on every INTEG en-cycle.
- With tau_shift!=0, leak floors; a small V may stall at a nonzero value (e.g. 1 with shift 1). This is intended.
- Configuration inputs are sampled each edge; no shadowing.
- refractory = (state==REFRAC), registered.

Optional Feature:
- Macro: LIF_ADAPT_THRESH_EN.
- Defined:
  - Internal W-bit register theta, reset to 0.
  - threshold_eff = sat(threshold + theta).
  - On each spike, theta <= sat(theta + ADAPT_INC).
  - On each INTEG en-cycle without a spike, theta decrements by 1, floored at 0.
  - theta holds during REFRAC.
- Undefined: threshold_eff = threshold; no theta register.

Decomposition:
- Package lif_pkg contains:
  - State typedef lif_state_t {INTEG, REFRAC}.
  - Saturating-add function sat_add.
  - Default width constants.
- Sub-module lif_syn_sum: combinational masked weight sum of N_SYN inputs, output width W+$clog2(N_SYN).

Test Plan (W=8, N_SYN=4):
1. syn=4'b0001 held, rst_n pulsed low during REFRAC -> V=0, spike=0, refractory=0 immediately, with no clock edge.
2. tau_shift=0, weight0=10, threshold=50, v_reset=0, refrac_cycles=0, syn0 held high -> V=10,20,30,40, then spike=1 with V=0 at the 5th edge; repeats every 5 cycles.
3. tau_shift=1, one cycle syn0 with weight0=100, then syn=0 -> V=100,50,25,13,7,4,2,1,1; no spike with threshold=200.
4. All weights=255, syn=4'hF, threshold=255 -> sum saturates, spike=1, V=v_reset; with threshold=0, spike every en-cycle.
5. refrac_cycles=3, spike, syn held high -> refractory=1 and V=v_reset for 3 en-cycles; integration resumes on the 4th. Toggling en=0 mid-refractory extends it by the idle cycles.
6. LIF_ADAPT_THRESH_EN, ADAPT_INC=4, threshold=20, weight0=10, syn0 held -> first spike at V>=20; next threshold_eff=24 minus the decay across cycles. Check the theta sequence each cycle against the model.
